spi_controller: RTL and testbench

SPI_CONTROLLER -- requirements
Module: spi_controller

---
 rtl/spi_controller.sv | 246 ++++++++++++++++++++++++
 tb/tb_spi_controller.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_controller.sv
// ---------------------------------------------------------------------------
// spi_controller
//
// Byte-oriented SPI Mode 0 (CPOL=0, CPHA=0) master. Bytes are offered on a
// valid/ready pair. The first accepted byte opens a transaction by dropping
// CS_n. Each byte is shifted out MSB first while the peripheral's reply is
// shifted in. A byte offered with i_txLast set closes the transaction after
// the CS hold time. CS_n then stays high for a minimum idle time.
//
// Handshake: a byte moves only on a rising i_clk edge where i_txDataValid
// and o_txReady are both high. i_txData and i_txLast are captured on that
// edge. i_txDataValid is ignored whenever o_txReady is low. o_txReady is
// high only in IDLE and NEXT.
//
// Ports
//   i_clk, i_rst_n   clock (rising edge), asynchronous active-low reset
//   i_txDataValid    byte offer strobe
//   i_txData[7:0]    byte to send, MSB first
//   i_txLast         offered byte is the last of the transaction
//   o_txReady        a byte can be accepted this cycle
//   o_rxDataValid    one-cycle pulse: o_rxData holds a newly received byte
//   o_rxData[7:0]    last received byte, held until the next pulse
//   o_busy           state is not IDLE
//   o_SPI_CLK        SPI clock, idle low
//   o_SPI_PICO       serial data to the peripheral
//   i_SPI_POCI       serial data from the peripheral
//   o_SPI_CS_n       active-low chip select
//   o_dbgState[2:0]  current FSM state encoding, for observation only
// ---------------------------------------------------------------------------
module spi_controller #(
    parameter int CLKS_PER_HALF_BIT = 2,
    parameter int CS_SETUP_CLKS     = 2,
    parameter int CS_HOLD_CLKS      = 2,
    parameter int CS_IDLE_CLKS      = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_txDataValid,
    input  logic [7:0] i_txData,
    input  logic       i_txLast,
    output logic       o_txReady,
    output logic       o_rxDataValid,
    output logic [7:0] o_rxData,
    output logic       o_busy,
    output logic       o_SPI_CLK,
    output logic       o_SPI_PICO,
    input  logic       i_SPI_POCI,
    output logic       o_SPI_CS_n,
    output logic [2:0] o_dbgState
);

    generate
        if (CLKS_PER_HALF_BIT < 2 || CLKS_PER_HALF_BIT > 255) begin : g_bad_half_bit
            $error("spi_controller: CLKS_PER_HALF_BIT must be in 2..255");
        end
        if (CS_SETUP_CLKS < 1 || CS_HOLD_CLKS < 1 || CS_IDLE_CLKS < 1) begin : g_bad_cs_timing
            $error("spi_controller: CS_SETUP/HOLD/IDLE_CLKS must be at least 1");
        end
    endgenerate

    // One shared counter times the three CS phases. It is sized for the
    // largest of them and restarts from zero on every phase change.
    localparam int CNT_MAX_SH = (CS_SETUP_CLKS > CS_HOLD_CLKS) ? CS_SETUP_CLKS : CS_HOLD_CLKS;
    localparam int CNT_MAX    = (CNT_MAX_SH > CS_IDLE_CLKS) ? CNT_MAX_SH : CS_IDLE_CLKS;
    localparam int CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int HALF_W     = $clog2(CLKS_PER_HALF_BIT);

    localparam logic [CNT_W-1:0]  SETUP_LAST = CNT_W'(CS_SETUP_CLKS - 1);
    localparam logic [CNT_W-1:0]  HOLD_LAST  = CNT_W'(CS_HOLD_CLKS - 1);
    localparam logic [CNT_W-1:0]  IDLE_LAST  = CNT_W'(CS_IDLE_CLKS - 1);
    localparam logic [HALF_W-1:0] HALF_LAST  = HALF_W'(CLKS_PER_HALF_BIT - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CS_SETUP = 3'd1,
        SHIFT    = 3'd2,
        NEXT     = 3'd3,
        CS_HOLD  = 3'd4,
        CS_IDLE  = 3'd5
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [HALF_W-1:0] half_q, half_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        tx_sh_q, tx_sh_d;
    logic              last_q, last_d;
    logic [7:0]        rx_sh_q, rx_sh_d;
    logic [7:0]        rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              cs_n_q, cs_n_d;
    logic              sclk_q, sclk_d;
    logic              pico_q, pico_d;
    logic              tx_ready_q, tx_ready_d;
    logic              busy_q, busy_d;
    logic              accept;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            half_q     <= '0;
            bit_q      <= '0;
            tx_sh_q    <= '0;
            last_q     <= 1'b0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            cs_n_q     <= 1'b1;
            sclk_q     <= 1'b0;
            pico_q     <= 1'b0;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            half_q     <= half_d;
            bit_q      <= bit_d;
            tx_sh_q    <= tx_sh_d;
            last_q     <= last_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            cs_n_q     <= cs_n_d;
            sclk_q     <= sclk_d;
            pico_q     <= pico_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        half_d     = half_q;
        bit_d      = bit_q;
        tx_sh_d    = tx_sh_q;
        last_d     = last_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        cs_n_d     = cs_n_q;
        sclk_d     = sclk_q;
        pico_d     = pico_q;
        accept     = i_txDataValid & tx_ready_q;

        case (state_q)
            IDLE: begin
                cs_n_d = 1'b1;
                sclk_d = 1'b0;
                pico_d = 1'b0;
                if (accept) begin
                    tx_sh_d = i_txData;
                    last_d  = i_txLast;
                    cnt_d   = '0;
                    cs_n_d  = 1'b0;
                    state_d = CS_SETUP;
                end
            end
            CS_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = '0;
                    half_d  = '0;
                    bit_d   = 3'd7;
                    pico_d  = tx_sh_q[7];
                    state_d = SHIFT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SHIFT: begin
                if (half_q == HALF_LAST) begin
                    half_d = '0;
                    sclk_d = ~sclk_q;
                    if (!sclk_q) begin
                        // Rising SPI_CLK edge: capture the peripheral's bit.
                        rx_sh_d = {rx_sh_q[6:0], i_SPI_POCI};
                    end else if (bit_q == 3'd0) begin
                        // Eighth falling edge: byte done. PICO keeps bit 0.
                        rx_data_d  = rx_sh_q;
                        rx_valid_d = 1'b1;
                        cnt_d      = '0;
                        state_d    = last_q ? CS_HOLD : NEXT;
                    end else begin
                        // Falling edge: present the next lower bit.
                        bit_d   = bit_q - 3'd1;
                        tx_sh_d = {tx_sh_q[6:0], 1'b0};
                        pico_d  = tx_sh_q[6];
                    end
                end else begin
                    half_d = half_q + 1'b1;
                end
            end
            NEXT: begin
                // CS_n stays low and SPI_CLK low for as long as it takes.
                if (accept) begin
                    tx_sh_d = i_txData;
                    last_d  = i_txLast;
                    half_d  = '0;
                    bit_d   = 3'd7;
                    pico_d  = i_txData[7];
                    state_d = SHIFT;
                end
            end
            CS_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = '0;
                    cs_n_d  = 1'b1;
                    pico_d  = 1'b0;
                    state_d = CS_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CS_IDLE: begin
                if (cnt_q == IDLE_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                cs_n_d  = 1'b1;
                sclk_d  = 1'b0;
                pico_d  = 1'b0;
                state_d = IDLE;
            end
        endcase

        // Status flags are registered from the next state so they line up
        // with the state they describe.
        tx_ready_d = (state_d == IDLE) || (state_d == NEXT);
        busy_d     = (state_d != IDLE);
    end

    assign o_txReady     = tx_ready_q;
    assign o_rxDataValid = rx_valid_q;
    assign o_rxData      = rx_data_q;
    assign o_busy        = busy_q;
    assign o_SPI_CLK     = sclk_q;
    assign o_SPI_PICO    = pico_q;
    assign o_SPI_CS_n    = cs_n_q;
    assign o_dbgState    = state_q;

endmodule

// File: tb/tb_spi_controller.sv
module tb_spi_controller;

  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_NEXT  = 3'd3;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // default-parameter DUT
  logic       txv = 1'b0;
  logic [7:0] txd = 8'h00;
  logic       txl = 1'b0;
  logic       tx_ready, rx_valid, busy, sclk, pico, cs_n, poci;
  logic [7:0] rx_data;
  logic [2:0] dbg;
  logic       loopback = 1'b1;

  spi_controller dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_txDataValid(txv), .i_txData(txd), .i_txLast(txl),
    .o_txReady(tx_ready), .o_rxDataValid(rx_valid), .o_rxData(rx_data),
    .o_busy(busy), .o_SPI_CLK(sclk), .o_SPI_PICO(pico),
    .i_SPI_POCI(poci), .o_SPI_CS_n(cs_n), .o_dbgState(dbg)
  );

  // DUT with a 5-cycle half period, looped back
  logic       txv5 = 1'b0;
  logic [7:0] txd5 = 8'h00;
  logic       txl5 = 1'b0;
  logic       tx_ready5, rx_valid5, busy5, sclk5, pico5, cs_n5;
  logic [7:0] rx_data5;
  logic [2:0] dbg5;

  spi_controller #(.CLKS_PER_HALF_BIT(5)) dut5 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_txDataValid(txv5), .i_txData(txd5), .i_txLast(txl5),
    .o_txReady(tx_ready5), .o_rxDataValid(rx_valid5), .o_rxData(rx_data5),
    .o_busy(busy5), .o_SPI_CLK(sclk5), .o_SPI_PICO(pico5),
    .i_SPI_POCI(pico5), .o_SPI_CS_n(cs_n5), .o_dbgState(dbg5)
  );

  // peripheral model: drives MSB first, advances after each SPI_CLK fall
  int         fall_cnt    = 0;
  int         fall_base   = 0;
  logic [7:0] periph_byte = 8'h00;
  logic       periph_bit;

  always @(negedge sclk) fall_cnt <= fall_cnt + 1;

  always_comb begin
    periph_bit = 1'b0;
    if ((fall_cnt - fall_base) >= 0 && (fall_cnt - fall_base) < 8)
      periph_bit = periph_byte[3'(7 - (fall_cnt - fall_base))];
  end

  assign poci = loopback ? pico : periph_bit;

  // bus monitor, sampled on the falling i_clk edge
  int         ncyc        = 0;
  int         rise_cnt    = 0;
  int         cs_rise_cnt = 0;
  int         rx_cnt      = 0;
  int         rise_cyc[$];
  int         rise5_cyc[$];
  logic [7:0] rx_log[$];
  logic [7:0] pico_sh     = 8'h00;
  logic       sclk_prev   = 1'b0;
  logic       sclk5_prev  = 1'b0;
  logic       cs_prev     = 1'b1;

  always @(negedge clk) begin
    ncyc       <= ncyc + 1;
    sclk_prev  <= sclk;
    sclk5_prev <= sclk5;
    cs_prev    <= cs_n;
    if (sclk && !sclk_prev) begin
      rise_cnt <= rise_cnt + 1;
      pico_sh  <= {pico_sh[6:0], pico};
      rise_cyc.push_back(ncyc + 1);
    end
    if (sclk5 && !sclk5_prev) rise5_cyc.push_back(ncyc + 1);
    if (cs_n && !cs_prev) cs_rise_cnt <= cs_rise_cnt + 1;
    if (rx_valid) begin
      rx_cnt <= rx_cnt + 1;
      rx_log.push_back(rx_data);
    end
  end

  // scoreboard
  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  task automatic chk1(input string tag, input logic obs, input logic expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, expv);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, expv);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int budget, input string tag);
    int n = 0;
    while (tx_ready !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk1(tag, tx_ready, 1'b1);
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    txd = d;
    txl = last;
    txv = 1'b1;
    tick();
    txv = 1'b0;
  endtask

  initial begin
    int base_r, base_q, base_rx, base_cs, base5, t0, r0, viol, n;

    // ---- reset ----
    #1 rst_n = 1'b0;
    #1;
    chk1("rst_cs_n", cs_n, 1'b1);
    chk1("rst_sclk", sclk, 1'b0);
    chk1("rst_pico", pico, 1'b0);
    chk1("rst_ready", tx_ready, 1'b0);
    chk1("rst_rx_valid", rx_valid, 1'b0);
    chk8("rst_rx_data", rx_data, 8'h00);
    chk1("rst_busy", busy, 1'b0);
    tick();
    tick();
    chk1("rst_ready_held", tx_ready, 1'b0);
    rst_n = 1'b1;
    chk1("rel_ready_before_edge", tx_ready, 1'b0);
    tick();
    chk1("rel_ready_first_edge", tx_ready, 1'b1);
    chk1("rel_busy", busy, 1'b0);

    // ---- single byte 0xA5, loopback ----
    loopback = 1'b1;
    base_r = rise_cnt; base_q = rise_cyc.size();
    send(8'hA5, 1'b1);
    t0 = ncyc;
    chk1("a_cs_fall", cs_n, 1'b0);
    chk1("a_ready_drop", tx_ready, 1'b0);
    chk1("a_busy", busy, 1'b1);
    tick();
    chk1("a_setup_pico", pico, 1'b0);
    chk1("a_setup_sclk", sclk, 1'b0);
    tick();
    chk1("a_first_bit", pico, 1'b1);
    chk1("a_first_sclk_low", sclk, 1'b0);
    chk8("a_state_shift", {5'd0, dbg}, {5'd0, ST_SHIFT});
    repeat (31) tick();
    chk1("a_last_half_high", sclk, 1'b1);
    chk1("a_no_early_rx", rx_valid, 1'b0);
    tick();
    chk1("a_rx_pulse", rx_valid, 1'b1);
    chk8("a_rx_data", rx_data, 8'hA5);
    chk1("a_sclk_low_end", sclk, 1'b0);
    chk1("a_cs_hold0", cs_n, 1'b0);
    tick();
    chk1("a_rx_pulse_one_cycle", rx_valid, 1'b0);
    chk1("a_cs_hold1", cs_n, 1'b0);
    tick();
    chk1("a_cs_rise", cs_n, 1'b1);
    chk1("a_idle_pico", pico, 1'b0);
    repeat (3) tick();
    chk1("a_ready_cs_idle", tx_ready, 1'b0);
    tick();
    chk1("a_ready_back", tx_ready, 1'b1);
    chkn("a_rise_count", rise_cnt - base_r, 8);
    chk8("a_pico_bits", pico_sh, 8'hA5);
    chkn("a_first_rise_delay", rise_cyc[base_q] - t0, 5);
    chkn("a_period", rise_cyc[base_q + 1] - rise_cyc[base_q], 4);
    chkn("a_eight_periods", rise_cyc[base_q + 7] - rise_cyc[base_q], 28);

    // ---- two bytes 0x3C, 0xF0; peripheral returns 0x81, 0x7E ----
    loopback = 1'b0;
    exp_q.push_back(8'h81);
    exp_q.push_back(8'h7E);
    periph_byte = 8'h81; fall_base = fall_cnt;
    base_r = rise_cnt; base_rx = rx_log.size(); base_cs = cs_rise_cnt;
    send(8'h3C, 1'b0);
    wait_ready(100, "b_next_timeout");
    chk8("b_state_next", {5'd0, dbg}, {5'd0, ST_NEXT});
    chk1("b_next_cs_low", cs_n, 1'b0);
    chk1("b_next_sclk_low", sclk, 1'b0);
    chk1("b_rx1_pulse", rx_valid, 1'b1);
    chk8("b_rx1_data", rx_data, 8'h81);
    periph_byte = 8'h7E; fall_base = fall_cnt;
    send(8'hF0, 1'b1);
    chk8("b_state_shift", {5'd0, dbg}, {5'd0, ST_SHIFT});
    chk1("b_byte2_msb", pico, 1'b1);
    chk1("b_byte2_ready_low", tx_ready, 1'b0);
    wait_ready(100, "b_end_timeout");
    chkn("b_rise_count", rise_cnt - base_r, 16);
    chkn("b_rx_count", rx_log.size() - base_rx, 2);
    chkn("b_cs_single_rise", cs_rise_cnt - base_cs, 1);
    chk8("b_rx_log0", rx_log[base_rx], exp_q.pop_front());
    chk8("b_rx_log1", rx_log[base_rx + 1], exp_q.pop_front());
    chk8("b_pico_byte2", pico_sh, 8'hF0);

    // ---- stall 50 cycles in NEXT, loopback 0x12 then 0xC3 ----
    loopback = 1'b1;
    base_rx = rx_log.size();
    send(8'h12, 1'b0);
    wait_ready(100, "c_next_timeout");
    viol = 0;
    r0 = rise_cnt;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (cs_n !== 1'b0 || sclk !== 1'b0 || tx_ready !== 1'b1) viol++;
    end
    chkn("c_stall_hold", viol, 0);
    chkn("c_stall_no_clk", rise_cnt - r0, 0);
    send(8'hC3, 1'b1);
    wait_ready(100, "c_end_timeout");
    chkn("c_rx_count", rx_log.size() - base_rx, 2);
    chk8("c_rx_byte1", rx_log[base_rx], 8'h12);
    chk8("c_rx_byte2", rx_data, 8'hC3);
    chk8("c_pico_byte2", pico_sh, 8'hC3);

    // ---- offers during SHIFT and CS_IDLE are ignored ----
    base_r = rise_cnt; base_rx = rx_log.size();
    send(8'h5A, 1'b1);
    repeat (5) tick();
    txd = 8'hFF; txl = 1'b0; txv = 1'b1;
    repeat (3) tick();
    txv = 1'b0;
    n = 0;
    while (cs_n !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk1("d_cs_rise_timeout", cs_n, 1'b1);
    txd = 8'h0F; txv = 1'b1;
    repeat (3) tick();
    txv = 1'b0;
    repeat (6) tick();
    chk1("d_not_busy", busy, 1'b0);
    chk1("d_cs_stays_high", cs_n, 1'b1);
    chk1("d_ready_idle", tx_ready, 1'b1);
    chkn("d_rise_count", rise_cnt - base_r, 8);
    chkn("d_rx_count", rx_log.size() - base_rx, 1);
    chk8("d_rx_data", rx_data, 8'h5A);
    chk8("d_pico_bits", pico_sh, 8'h5A);

    // ---- reset at bit 4 aborts, then 0x55 completes ----
    base_rx = rx_log.size();
    send(8'h96, 1'b1);
    repeat (16) tick();
    chk1("e_bit4_sclk_high", sclk, 1'b1);
    chk8("e_bit4_state", {5'd0, dbg}, {5'd0, ST_SHIFT});
    rst_n = 1'b0;
    #2;
    chk1("e_async_cs_n", cs_n, 1'b1);
    chk1("e_async_sclk", sclk, 1'b0);
    chk1("e_async_pico", pico, 1'b0);
    chk1("e_async_busy", busy, 1'b0);
    chk1("e_async_ready", tx_ready, 1'b0);
    chk8("e_async_rx_data", rx_data, 8'h00);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chkn("e_no_rx_pulse", rx_log.size() - base_rx, 0);
    chk1("e_ready_after_release", tx_ready, 1'b1);
    base_r = rise_cnt;
    send(8'h55, 1'b1);
    wait_ready(100, "e_new_timeout");
    chkn("e_new_rx_count", rx_log.size() - base_rx, 1);
    chk8("e_new_rx_data", rx_data, 8'h55);
    chkn("e_new_rise_count", rise_cnt - base_r, 8);
    chk8("e_new_pico_bits", pico_sh, 8'h55);

    // ---- CLKS_PER_HALF_BIT = 5 ----
    base5 = rise5_cyc.size();
    txd5 = 8'hC6; txl5 = 1'b1; txv5 = 1'b1;
    tick();
    txv5 = 1'b0;
    n = 0;
    while (rx_valid5 !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    chkn("f_byte_time", n, 82);
    chk8("f_rx_data", rx_data5, 8'hC6);
    chkn("f_period", rise5_cyc[base5 + 1] - rise5_cyc[base5], 10);
    chkn("f_eight_periods", rise5_cyc[base5 + 7] - rise5_cyc[base5], 70);
    chkn("f_rise_count", rise5_cyc.size() - base5, 8);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
